// File: rtl/instr_fetch_pkg.sv
// Shared fetch-unit types and constants.
// Holds the fetch FSM state type, the NOP encoding and the default reset PC.
package package_param;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DROP  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP          = 32'h0000_0013;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory request/response bus.
// One request pulse per fetch, in-order single-cycle ack with data.
interface instr_fetch_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Prefetch queue: DEPTH entries of {pc, instr}, synchronous flush.
// DEPTH must be a power of two (2 or 4) so pointers wrap naturally.
module fetch_queue
  import package_param::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        push,
    input  logic [63:0] wdata,
    input  logic        pop,
    output logic [63:0] head,
    output logic [2:0]  count
);
    localparam int PW = (DEPTH == 4) ? 2 : 1;

    logic [63:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + {2'b00, push} - {2'b00, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush && !rst) mem[wr_ptr] <= wdata;
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding imem request, prefetch queue, redirect.
// Define IF_BYPASS_EN for a zero-cycle ack->valid path when the queue is empty.
module instr_fetch
  import package_param::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter int          QDEPTH   = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_pc_sel,
    input  logic [31:0]          i_alu_data,
    input  logic                 i_stall,
    instr_fetch_if.master        imem,
    output logic [31:0]          o_instr,
    output logic [31:0]          o_pc,
    output logic                 o_instr_vld
);
    localparam logic [1:0] FETCH = ST_FETCH;
    localparam logic [1:0] WAIT  = ST_WAIT;
    localparam logic [1:0] DROP  = ST_DROP;
    localparam logic [2:0] QD    = 3'(QDEPTH);

    logic [1:0]  state;
    logic [31:0] fpc;
    logic [31:0] req_pc;
    logic [31:0] last_pc;
    logic [2:0]  q_count;
    logic [63:0] q_head;
    logic        q_vld;
    logic        accept;
    logic        byp;
    logic        redirect;
    logic        issue;
    logic        push;
    logic        pop;
    logic        unused_bits;

    assign unused_bits = ^i_alu_data[1:0];
    assign q_vld  = (q_count != 3'd0);
    assign accept = imem.ack && (state == WAIT);

`ifdef IF_BYPASS_EN
    assign byp = accept && !q_vld && !i_reset;
`else
    assign byp = 1'b0;
`endif

    assign o_instr_vld = q_vld || byp;
    assign redirect    = i_pc_sel && o_instr_vld && !i_stall;
    assign issue       = (state == FETCH) && (q_count < QD)
                         && !redirect && !i_reset;
    // A bypassed word consumed the same cycle never enters the queue.
    assign push = accept && !redirect && !i_reset && !(byp && !i_stall);
    assign pop  = q_vld && !i_stall;

    assign imem.req  = issue;
    assign imem.addr = fpc;

    always_comb begin
        o_instr = NOP;
        o_pc    = last_pc;
        if (q_vld) begin
            o_instr = q_head[31:0];
            o_pc    = q_head[63:32];
        end else if (byp) begin
            o_instr = imem.rdata;
            o_pc    = req_pc;
        end
    end

    fetch_queue #(.DEPTH(QDEPTH)) u_queue (
        .clk   (i_clk),
        .rst   (i_reset),
        .flush (redirect),
        .push  (push),
        .wdata ({req_pc, imem.rdata}),
        .pop   (pop),
        .head  (q_head),
        .count (q_count)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            // An abandoned request still owes an ack; swallow it later.
            state   <= (state != FETCH && !imem.ack) ? DROP : FETCH;
            fpc     <= RESET_PC;
            req_pc  <= RESET_PC;
            last_pc <= RESET_PC;
        end else begin
            if (o_instr_vld) last_pc <= o_pc;
            if (issue) begin
                req_pc <= fpc;
                fpc    <= fpc + 32'd4;
            end
            if (redirect) fpc <= {i_alu_data[31:2], 2'b00};
            case (state)
                FETCH: if (issue) state <= WAIT;
                WAIT: begin
                    if (imem.ack)     state <= FETCH;
                    else if (redirect) state <= DROP;
                end
                DROP: if (imem.ack) state <= FETCH;
                default: state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed table, corner sequences,
// and random traffic against an architectural instruction-stream model.
module tb_instr_fetch;
    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam int          QD  = 2;
    localparam logic [31:0] NOPW = 32'h0000_0013;
`ifdef IF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_sel = 1'b0;
    logic [31:0] alu = '0;
    logic        stall = 1'b0;
    logic [31:0] instr, pc;
    logic        vld;

    bit          auto_mem = 1'b0;
    logic        tb_ack = 1'b0;
    logic [31:0] tb_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    int          mem_lat = 0;

    int checks = 0;
    int errors = 0;

    instr_fetch_if bus ();
    assign bus.ack   = auto_mem ? mem_ack : tb_ack;
    assign bus.rdata = auto_mem ? mem_rdata : tb_rdata;

    instr_fetch #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_pc_sel    (pc_sel),
        .i_alu_data  (alu),
        .i_stall     (stall),
        .imem        (bus),
        .o_instr     (instr),
        .o_pc        (pc),
        .o_instr_vld (vld)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a + 32'h0050_0093;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Memory model: answers each request after mem_lat extra cycles.
    bit          pend = 1'b0;
    logic [31:0] paddr;
    int          dly;
    always @(negedge clk) begin
        if (auto_mem && bus.req) begin
            pend  = 1'b1;
            paddr = bus.addr;
            dly   = (mem_lat < 0) ? int'($urandom_range(3, 0)) : mem_lat;
        end
    end
    always @(posedge clk) begin
        #1;
        mem_ack = 1'b0;
        if (auto_mem && pend) begin
            if (dly == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = memf(paddr);
                pend      = 1'b0;
            end else begin
                dly--;
            end
        end
    end

    // Reference: the consumed stream must follow program order.
    logic [31:0] exp_pc = RPC;
    bit          hold = 1'b0;
    logic [31:0] h_pc, h_instr;
    int          outst = 0;
    int          consumed = 0;
    always @(negedge clk) begin
        if (rst) begin
            exp_pc = RPC;
            hold   = 1'b0;
        end else begin
            if (hold) begin
                chk("stall_vld", {31'b0, vld}, 32'd1);
                chk("stall_pc", pc, h_pc);
                chk("stall_instr", instr, h_instr);
            end
            if (!vld) chk("idle_nop", instr, NOPW);
            if (vld && !stall) begin
                chk("pc_order", pc, exp_pc);
                chk("instr_data", instr, memf(pc));
                consumed++;
                exp_pc = pc_sel ? {alu[31:2], 2'b00} : exp_pc + 32'd4;
            end
            hold    = vld && stall;
            h_pc    = pc;
            h_instr = instr;
        end
        if (bus.req) begin
            if (outst != 0) chk("one_outstanding", outst, 0);
            outst++;
        end
        if (bus.ack) outst--;
    end

    task automatic do_reset();
        cyc();
        rst = 1'b1;
        pc_sel = 1'b0;
        stall = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic wait_req(output logic [31:0] a);
        bit ok;
        ok = 1'b0;
        a  = 'x;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.req) begin
                a  = bus.addr;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("req_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_vld(input bit need_req);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (vld && (bus.req || !need_req)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("vld_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        bit          rst;
        bit          ack;
        logic [31:0] rdata;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_vld;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t tbl [7];

    initial begin
        logic [31:0] a;
        int n, c0;

        tbl[0] = '{1, 0, 0,         0, 0, 0,    RPC,  NOPW};
        tbl[1] = '{0, 0, 0,         1, 0, 0,    RPC,  NOPW};
        tbl[2] = '{0, 1, memf(0),   0, 0, BYP,  0,
                   BYP ? memf(0) : NOPW};
        tbl[3] = '{0, 0, 0,         1, 4, !BYP, 0,
                   BYP ? NOPW : memf(0)};
        tbl[4] = '{0, 1, memf(4),   0, 0, BYP,  BYP ? 32'd4 : 32'd0,
                   BYP ? memf(4) : NOPW};
        tbl[5] = '{0, 0, 0,         1, 8, !BYP, 4,
                   BYP ? NOPW : memf(4)};
        tbl[6] = '{0, 1, memf(8),   0, 0, BYP,  BYP ? 32'd8 : 32'd4,
                   BYP ? memf(8) : NOPW};

        repeat (2) cyc();
        for (int i = 0; i < 7; i++) begin
            cyc();
            rst      = tbl[i].rst;
            tb_ack   = tbl[i].ack;
            tb_rdata = tbl[i].rdata;
            @(negedge clk);
            chk($sformatf("v%0d_req", i), {31'b0, bus.req},
                {31'b0, tbl[i].e_req});
            if (tbl[i].e_req) chk($sformatf("v%0d_addr", i), bus.addr,
                                  tbl[i].e_addr);
            chk($sformatf("v%0d_vld", i), {31'b0, vld},
                {31'b0, tbl[i].e_vld});
            chk($sformatf("v%0d_pc", i), pc, tbl[i].e_pc);
            chk($sformatf("v%0d_instr", i), instr, tbl[i].e_instr);
        end
        cyc();
        tb_ack   = 1'b0;
        rst      = 1'b1;
        auto_mem = 1'b1;
        mem_lat  = 0;

        // Stall from the first cycle: queue fills, then issue stops.
        do_reset();
        stall = 1'b1;
        n = 0;
        for (int i = 0; i < 2 * QD + 6; i++) begin
            @(negedge clk);
            if (bus.req) n++;
        end
        chk("fill_reqs", n, QD);
        chk("fill_vld", {31'b0, vld}, 32'd1);
        chk("fill_pc", pc, RPC);
        cyc();
        stall = 1'b0;
        c0 = consumed;
        for (int i = 0; i < 60 && consumed < c0 + QD + 2; i++) cyc();
        chk("drain_progress", {31'b0, consumed >= c0 + QD + 2}, 32'd1);

        // Redirect while a request is outstanding.
        mem_lat = 2;
        do_reset();
        stall = 1'b1;
        wait_vld(1'b1);
        cyc();
        pc_sel = 1'b1;
        alu    = 32'h0000_0101;
        stall  = 1'b0;
        cyc();
        pc_sel = 1'b0;
        wait_req(a);
        chk("redir_addr", a, 32'h0000_0100);
        wait_vld(1'b0);
        chk("redir_first_pc", pc, 32'h0000_0100);

        // Fetch PC wrap.
        mem_lat = 0;
        cyc();
        stall = 1'b1;
        wait_vld(1'b0);
        cyc();
        stall  = 1'b0;
        pc_sel = 1'b1;
        alu    = 32'hFFFF_FFFE;
        cyc();
        pc_sel = 1'b0;
        wait_req(a);
        chk("wrap_addr0", a, 32'hFFFF_FFFC);
        wait_req(a);
        chk("wrap_addr1", a, 32'h0000_0000);

        // Reset with a request outstanding; its ack lands after reset.
        mem_lat = 1;
        do_reset();
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.req && bus.addr == 32'd8) begin
                n = 1;
                break;
            end
        end
        chk("rst_mid_found", n, 1);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_drop_vld", {31'b0, vld}, 32'd0);
        wait_vld(1'b0);
        chk("rst_mid_first_pc", pc, RPC);

        // Random traffic.
        mem_lat = -1;
        do_reset();
        c0 = consumed;
        for (int i = 0; i < 3000; i++) begin
            cyc();
            stall  = ($urandom_range(9, 0) < 3);
            pc_sel = ($urandom_range(4, 0) == 0);
            alu    = ($urandom_range(3, 0) == 0)
                     ? 32'hFFFF_FFF0 + 32'($urandom_range(15, 0))
                     : $urandom;
            rst    = ($urandom_range(399, 0) == 0);
        end
        cyc();
        rst = 1'b0;
        stall = 1'b0;
        pc_sel = 1'b0;
        chk("rand_progress", {31'b0, consumed > c0 + 200}, 32'd1);
        repeat (5) cyc();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
